chan_cmd_responder: RTL and testbench



---
 rtl/chan_cmd_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_chan_cmd_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_cmd_responder.sv
// chan_cmd_responder: channel-side command executor for the master link.
// Accepts READ/WRITE command frames from the RX stream, performs one access
// on the local register bus, and returns one response frame per command.
// Malformed frames are drained, answered with status F and counted.
module chan_cmd_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic         axis_aclk,
  input  logic         axis_aresetn,
  input  logic [0:15]  s_axis_rx_tdata,
  input  logic [0:1]   s_axis_rx_tkeep,
  input  logic         s_axis_rx_tvalid,
  input  logic         s_axis_rx_tlast,
  output logic         s_axis_rx_tready,
  output logic [0:15]  m_axis_tx_tdata,
  output logic [0:1]   m_axis_tx_tkeep,
  output logic         m_axis_tx_tvalid,
  output logic         m_axis_tx_tlast,
  input  logic         m_axis_tx_tready,
  output logic [11:0]  io_addr,
  output logic         io_wr_en,
  output logic         io_rd_en,
  output logic [31:0]  io_wr_data,
  input  logic [31:0]  io_rd_data,
  input  logic         io_rd_ack,
  output logic [15:0]  frame_err_count
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_GET_WHI  = 4'd1;
  localparam logic [3:0] ST_GET_WLO  = 4'd2;
  localparam logic [3:0] ST_DRAIN    = 4'd3;
  localparam logic [3:0] ST_WR_STB   = 4'd4;
  localparam logic [3:0] ST_RD_STB   = 4'd5;
  localparam logic [3:0] ST_RD_WAIT  = 4'd6;
  localparam logic [3:0] ST_SEND_HDR = 4'd7;
  localparam logic [3:0] ST_SEND_DHI = 4'd8;
  localparam logic [3:0] ST_SEND_DLO = 4'd9;

  localparam logic [3:0] OP_READ   = 4'h1;
  localparam logic [3:0] OP_WRITE  = 4'h2;
  localparam logic [3:0] STS_RD_OK = 4'h1;
  localparam logic [3:0] STS_WR_OK = 4'h2;
  localparam logic [3:0] STS_TMO   = 4'hE;
  localparam logic [3:0] STS_BAD   = 4'hF;

  logic [3:0]  state_q, state_d;
  logic        rx_ready_q;
  logic [11:0] resp_addr_q;
  logic [15:0] whi_q;
  logic [31:0] rd_data_q;
  logic [3:0]  status_q, status_d;
  logic [15:0] wait_q;
  logic [11:0] io_addr_q;
  logic [31:0] io_wr_data_q;
  logic        io_wr_en_q, io_rd_en_q;
  logic [15:0] err_cnt_q;
  logic        tx_valid_q, tx_last_q;
  logic [0:15] tx_data_q;
  logic [0:1]  tx_keep_q;

  logic        rx_fire, tx_fire, keep_ok, hdr_bad, enter_hdr;
  logic [3:0]  opcode;
  logic [11:0] rx_addr, hdr_addr_d;

  assign s_axis_rx_tready = rx_ready_q;
  assign m_axis_tx_tdata  = tx_data_q;
  assign m_axis_tx_tkeep  = tx_keep_q;
  assign m_axis_tx_tvalid = tx_valid_q;
  assign m_axis_tx_tlast  = tx_last_q;
  assign io_addr          = io_addr_q;
  assign io_wr_en         = io_wr_en_q;
  assign io_rd_en         = io_rd_en_q;
  assign io_wr_data       = io_wr_data_q;
  assign frame_err_count  = err_cnt_q;

  // Frame decode and next-state selection, including the status of any response being started.
  always_comb begin
    rx_fire    = s_axis_rx_tvalid && rx_ready_q;
    tx_fire    = tx_valid_q && m_axis_tx_tready;
    keep_ok    = (s_axis_rx_tkeep == 2'b11);
    opcode     = s_axis_rx_tdata[0:3];
    rx_addr    = s_axis_rx_tdata[4:15];
    hdr_bad    = !((opcode == OP_READ) || (opcode == OP_WRITE)) || !keep_ok;
    // A response can start straight from IDLE, before resp_addr_q has captured the header.
    hdr_addr_d = (state_q == ST_IDLE) ? (hdr_bad ? 12'h000 : rx_addr) : resp_addr_q;
    state_d    = state_q;
    status_d   = status_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (hdr_bad) begin
            status_d = STS_BAD;
            state_d  = s_axis_rx_tlast ? ST_SEND_HDR : ST_DRAIN;
          end else if (opcode == OP_READ) begin
            status_d = STS_BAD;
            state_d  = s_axis_rx_tlast ? ST_RD_STB : ST_DRAIN;
          end else begin
            status_d = STS_BAD;
            state_d  = s_axis_rx_tlast ? ST_SEND_HDR : ST_GET_WHI;
          end
        end
      end
      ST_GET_WHI: begin
        if (rx_fire) begin
          if (!keep_ok || s_axis_rx_tlast) begin
            status_d = STS_BAD;
            state_d  = s_axis_rx_tlast ? ST_SEND_HDR : ST_DRAIN;
          end else begin
            state_d = ST_GET_WLO;
          end
        end
      end
      ST_GET_WLO: begin
        if (rx_fire) begin
          if (!keep_ok) begin
            status_d = STS_BAD;
            state_d  = s_axis_rx_tlast ? ST_SEND_HDR : ST_DRAIN;
          end else if (s_axis_rx_tlast) begin
            state_d = ST_WR_STB;
          end else begin
            status_d = STS_BAD;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rx_fire && s_axis_rx_tlast) begin
          status_d = STS_BAD;
          state_d  = ST_SEND_HDR;
        end
      end
      ST_WR_STB: begin
        status_d = STS_WR_OK;
        state_d  = ST_SEND_HDR;
      end
      ST_RD_STB: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (io_rd_ack) begin
          status_d = STS_RD_OK;
          state_d  = ST_SEND_HDR;
        end else if (wait_q == 16'(TIMEOUT)) begin
          status_d = STS_TMO;
          state_d  = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        if (tx_fire) state_d = (status_q == STS_RD_OK) ? ST_SEND_DHI : ST_IDLE;
      end
      ST_SEND_DHI: begin
        if (tx_fire) state_d = ST_SEND_DLO;
      end
      ST_SEND_DLO: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    enter_hdr = (state_d == ST_SEND_HDR) && (state_q != ST_SEND_HDR);
  end

  // State, bus strobes, captured data, error counter and the registered TX beat.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      resp_addr_q  <= '0;
      whi_q        <= '0;
      rd_data_q    <= '0;
      status_q     <= '0;
      wait_q       <= '0;
      io_addr_q    <= '0;
      io_wr_data_q <= '0;
      io_wr_en_q   <= 1'b0;
      io_rd_en_q   <= 1'b0;
      err_cnt_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_keep_q    <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == ST_IDLE) || (state_d == ST_GET_WHI) ||
                    (state_d == ST_GET_WLO) || (state_d == ST_DRAIN);
      io_wr_en_q <= (state_d == ST_WR_STB);
      io_rd_en_q <= (state_d == ST_RD_STB);

      if ((state_q == ST_IDLE) && rx_fire) resp_addr_q <= hdr_addr_d;
      if ((state_q == ST_GET_WHI) && rx_fire) whi_q <= s_axis_rx_tdata;
      if ((state_q == ST_IDLE) && (state_d == ST_RD_STB)) io_addr_q <= rx_addr;
      if ((state_q == ST_GET_WLO) && (state_d == ST_WR_STB)) begin
        io_addr_q    <= resp_addr_q;
        io_wr_data_q <= {whi_q, s_axis_rx_tdata};
      end

      if (state_q == ST_RD_STB) wait_q <= 16'd1;
      else if (state_q == ST_RD_WAIT) wait_q <= wait_q + 16'd1;
      if ((state_q == ST_RD_WAIT) && io_rd_ack) rd_data_q <= io_rd_data;

      if (enter_hdr) begin
        status_q   <= status_d;
        tx_valid_q <= 1'b1;
        tx_keep_q  <= 2'b11;
        tx_data_q  <= {status_d, hdr_addr_d};
        tx_last_q  <= (status_d != STS_RD_OK);
        if ((status_d == STS_BAD) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (tx_fire) begin
        if ((state_q == ST_SEND_HDR) && (status_q == STS_RD_OK)) begin
          tx_data_q <= rd_data_q[31:16];
          tx_last_q <= 1'b0;
        end else if (state_q == ST_SEND_DHI) begin
          tx_data_q <= rd_data_q[15:0];
          tx_last_q <= 1'b1;
        end else begin
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
          tx_keep_q  <= '0;
          tx_data_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chan_cmd_responder.sv
// Directed bench for chan_cmd_responder: read, write, timeout, malformed
// frames, TX backpressure and reset during a pending read.
`define CHK(t, o, e) check(t, 128'(o), 128'(e))

module tb_chan_cmd_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:15]  s_axis_rx_tdata = '0;
  logic [0:1]   s_axis_rx_tkeep = '0;
  logic         s_axis_rx_tvalid = 1'b0;
  logic         s_axis_rx_tlast = 1'b0;
  logic         s_axis_rx_tready;
  logic [0:15]  m_axis_tx_tdata;
  logic [0:1]   m_axis_tx_tkeep;
  logic         m_axis_tx_tvalid;
  logic         m_axis_tx_tlast;
  logic         m_axis_tx_tready = 1'b0;
  logic [11:0]  io_addr;
  logic         io_wr_en;
  logic         io_rd_en;
  logic [31:0]  io_wr_data;
  logic [31:0]  io_rd_data = '0;
  logic         io_rd_ack = 1'b0;
  logic [15:0]  frame_err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  logic [82:0] all_out;
  assign all_out = {s_axis_rx_tready, m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tkeep,
                    m_axis_tx_tdata, io_addr, io_wr_en, io_rd_en, io_wr_data, frame_err_count};

  chan_cmd_responder #(.TIMEOUT(8)) dut (
    .axis_aclk        (clk),
    .axis_aresetn     (rst_n),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tready (s_axis_rx_tready),
    .m_axis_tx_tdata  (m_axis_tx_tdata),
    .m_axis_tx_tkeep  (m_axis_tx_tkeep),
    .m_axis_tx_tvalid (m_axis_tx_tvalid),
    .m_axis_tx_tlast  (m_axis_tx_tlast),
    .m_axis_tx_tready (m_axis_tx_tready),
    .io_addr          (io_addr),
    .io_wr_en         (io_wr_en),
    .io_rd_en         (io_rd_en),
    .io_wr_data       (io_wr_data),
    .io_rd_data       (io_rd_data),
    .io_rd_ack        (io_rd_ack),
    .frame_err_count  (frame_err_count)
  );

  always #5 clk = ~clk;

  // Strobe cycles counted mid-cycle.
  always @(negedge clk) begin
    if (io_rd_en) rd_pulses++;
    if (io_wr_en) wr_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    int n = 0;
    s_axis_rx_tdata  = d;
    s_axis_rx_tkeep  = k;
    s_axis_rx_tlast  = l;
    s_axis_rx_tvalid = 1'b1;
    while (!s_axis_rx_tready && n < 50) begin
      tick();
      n++;
    end
    `CHK("rx_tready_wait", s_axis_rx_tready, 1'b1);
    tick();
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
  endtask

  task automatic recv_word(input string tag, input logic [15:0] exp, input logic l);
    int n = 0;
    m_axis_tx_tready = 1'b1;
    while (!m_axis_tx_tvalid && n < 50) begin
      tick();
      n++;
    end
    `CHK(tag, {m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast, m_axis_tx_tkeep},
         {1'b1, exp, l, 2'b11});
    tick();
  endtask

  initial begin
    logic [15:0] bp_words [3];
    logic [2:0]  bp_lasts;
    logic [16:0] held;
    logic        stalled;
    int          got, stall_bad, rx_bad, stale;

    // Reset state
    tick();
    tick();
    `CHK("reset_outputs", all_out, 83'd0);
    rst_n = 1'b1;
    `CHK("tready_before_edge", s_axis_rx_tready, 1'b0);
    tick();
    `CHK("tready_first_edge", s_axis_rx_tready, 1'b1);

    // READ 0xABC, ack 3 cycles after the strobe with 0x12345678
    m_axis_tx_tready = 1'b1;
    send_beat(16'h1ABC, 2'b11, 1'b1);
    `CHK("rd_strobe", {io_rd_en, io_wr_en, io_addr}, {1'b1, 1'b0, 12'hABC});
    `CHK("rd_tready_low", s_axis_rx_tready, 1'b0);
    io_rd_ack = 1'b1;   // same cycle as io_rd_en: must be ignored
    io_rd_data = 32'hBAD0BAD0;
    tick();
    io_rd_ack = 1'b0;
    `CHK("rd_strobe_width", io_rd_en, 1'b0);
    tick();
    tick();
    `CHK("rd_no_early_resp", m_axis_tx_tvalid, 1'b0);
    io_rd_ack = 1'b1;
    io_rd_data = 32'h12345678;
    tick();
    io_rd_ack = 1'b0;
    io_rd_data = '0;
    `CHK("rd_resp_latency", {m_axis_tx_tvalid, m_axis_tx_tdata}, {1'b1, 16'h1ABC});
    recv_word("rd_hdr", 16'h1ABC, 1'b0);
    recv_word("rd_dhi", 16'h1234, 1'b0);
    recv_word("rd_dlo", 16'h5678, 1'b1);
    `CHK("rd_done", {m_axis_tx_tvalid, m_axis_tx_tkeep, s_axis_rx_tready}, {1'b0, 2'b00, 1'b1});
    `CHK("rd_pulses", rd_pulses, 1);

    // WRITE 0x010 <= 0xCAFEF00D
    send_beat(16'h2010, 2'b11, 1'b0);
    send_beat(16'hCAFE, 2'b11, 1'b0);
    send_beat(16'hF00D, 2'b11, 1'b1);
    `CHK("wr_strobe", {io_wr_en, io_rd_en, io_addr, io_wr_data},
         {1'b1, 1'b0, 12'h010, 32'hCAFEF00D});
    `CHK("wr_no_resp_yet", m_axis_tx_tvalid, 1'b0);
    tick();
    `CHK("wr_resp", {io_wr_en, m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast, m_axis_tx_tkeep},
         {1'b0, 1'b1, 16'h2010, 1'b1, 2'b11});
    tick();
    `CHK("wr_done", {m_axis_tx_tvalid, s_axis_rx_tready, io_addr, io_wr_data},
         {1'b0, 1'b1, 12'h010, 32'hCAFEF00D});
    `CHK("wr_pulses", wr_pulses, 1);

    // Timeout: READ 0x005, no ack, TIMEOUT = 8
    m_axis_tx_tready = 1'b0;
    send_beat(16'h1005, 2'b11, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    `CHK("tmo_not_before_8", m_axis_tx_tvalid, 1'b0);
    tick();
    `CHK("tmo_resp", {m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast}, {1'b1, 16'hE005, 1'b1});
    io_rd_ack = 1'b1;
    io_rd_data = 32'hFFFFFFFF;
    tick();
    tick();
    io_rd_ack = 1'b0;
    `CHK("tmo_late_ack_ignored", {m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast},
         {1'b1, 16'hE005, 1'b1});
    m_axis_tx_tready = 1'b1;
    tick();
    `CHK("tmo_done", {m_axis_tx_tvalid, s_axis_rx_tready}, {1'b0, 1'b1});
    `CHK("tmo_rd_pulses", rd_pulses, 2);

    // Malformed: WRITE with tlast on word 1
    send_beat(16'h2123, 2'b11, 1'b0);
    send_beat(16'h1111, 2'b11, 1'b1);
    `CHK("bad_early_last_cnt", frame_err_count, 16'd1);
    recv_word("bad_early_last", 16'hF123, 1'b1);
    // Malformed: 5-word frame with opcode 7
    send_beat(16'h7456, 2'b11, 1'b0);
    send_beat(16'h0001, 2'b11, 1'b0);
    send_beat(16'h0002, 2'b11, 1'b0);
    send_beat(16'h0003, 2'b11, 1'b0);
    `CHK("bad_op_draining", {m_axis_tx_tvalid, s_axis_rx_tready}, {1'b0, 1'b1});
    send_beat(16'h0004, 2'b11, 1'b1);
    recv_word("bad_opcode", 16'hF000, 1'b1);
    // Malformed: READ with tkeep = 2'b10
    send_beat(16'h1ABC, 2'b10, 1'b1);
    recv_word("bad_tkeep", 16'hF000, 1'b1);
    `CHK("bad_err_count", frame_err_count, 16'd3);
    `CHK("bad_no_strobes", {rd_pulses, wr_pulses}, {32'd2, 32'd1});

    // Backpressure during a READ response
    send_beat(16'h1077, 2'b11, 1'b1);
    tick();
    io_rd_ack = 1'b1;
    io_rd_data = 32'hDEADBEEF;
    tick();
    io_rd_ack = 1'b0;
    got = 0; stall_bad = 0; rx_bad = 0; stalled = 1'b0; held = '0; bp_lasts = '0;
    for (int i = 0; i < 200 && got < 3; i++) begin
      if (stalled && !(m_axis_tx_tvalid && ({m_axis_tx_tdata, m_axis_tx_tlast} == held)))
        stall_bad++;
      if (s_axis_rx_tready) rx_bad++;
      if (i == 0) m_axis_tx_tready = 1'b0;
      else if (i > 12) m_axis_tx_tready = 1'b1;
      else m_axis_tx_tready = 1'($urandom_range(0, 1));
      stalled = m_axis_tx_tvalid && !m_axis_tx_tready;
      held = {m_axis_tx_tdata, m_axis_tx_tlast};
      if (m_axis_tx_tvalid && m_axis_tx_tready) begin
        bp_words[got] = m_axis_tx_tdata;
        bp_lasts[got] = m_axis_tx_tlast;
        got++;
      end
      tick();
    end
    `CHK("bp_word_count", got, 3);
    `CHK("bp_words", {bp_words[0], bp_words[1], bp_words[2], bp_lasts},
         {16'h1077, 16'hDEAD, 16'hBEEF, 3'b100});
    `CHK("bp_stall_stable", stall_bad, 0);
    `CHK("bp_rx_tready_low", rx_bad, 0);
    `CHK("bp_done", {m_axis_tx_tvalid, s_axis_rx_tready}, {1'b0, 1'b1});

    // Reset while in RD_WAIT, then a WRITE
    send_beat(16'h1333, 2'b11, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    `CHK("rst_async_outputs", all_out, 83'd0);
    tick();
    `CHK("rst_held_outputs", all_out, 83'd0);
    rst_n = 1'b1;
    tick();
    `CHK("rst_tready_back", {s_axis_rx_tready, m_axis_tx_tvalid}, {1'b1, 1'b0});
    io_rd_ack = 1'b1;
    io_rd_data = 32'h55555555;
    tick();
    io_rd_ack = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_axis_tx_tvalid) stale++;
      tick();
    end
    `CHK("rst_no_stale_resp", stale, 0);
    send_beat(16'h2456, 2'b11, 1'b0);
    send_beat(16'h1111, 2'b11, 1'b0);
    send_beat(16'h2222, 2'b11, 1'b1);
    `CHK("rst_wr_strobe", {io_wr_en, io_addr, io_wr_data}, {1'b1, 12'h456, 32'h11112222});
    recv_word("rst_wr_resp", 16'h2456, 1'b1);
    `CHK("rst_err_count", frame_err_count, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
